// File: rtl/if_id_skid_stage_pkg.sv
// Shared IF/ID pipeline package.
// Holds the default field widths, the default NOP instruction, the occupancy
// encoding {main_valid, skid_valid} used by the skid stage, the {pc, inst}
// payload type shared by the pipeline stage registers, and a legality helper
// for the occupancy encoding.
package if_id_skid_stage_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = '0;

  // Occupancy encoding: bit 1 = main entry valid, bit 0 = skid entry valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b10,
    OCC_FULL  = 2'b11
  } occ_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } if_id_payload_t;

  // A skid entry without a main entry would break FIFO ordering.
  function automatic logic occ_legal(input logic [1:0] occ);
    return occ != 2'b01;
  endfunction

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Valid/ready handshake bundle carrying one {pc, inst} entry.
//   valid : producer presents an entry
//   ready : consumer can take it
//   pc    : program counter, PC_W bits
//   inst  : instruction word, INST_W bits
// master = producer side, slave = consumer side.
interface if_id_skid_stage_if #(
  parameter int unsigned PC_W   = if_id_skid_stage_pkg::PC_W_DEF,
  parameter int unsigned INST_W = if_id_skid_stage_pkg::INST_W_DEF
);

  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;

  modport master (output valid, output pc, output inst, input ready);
  modport slave  (input valid, input pc, input inst, output ready);

endinterface

// File: rtl/if_id_skid_stage_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports:
//   clk   : pipeline clock, updates on the falling edge
//   reset : asynchronous active-low reset, clears the count
//   inc   : increment enable for this cycle
//   count : registered count value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CountMax = '1;

  // Saturating increment
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != CountMax)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: IF/ID pipeline register with valid/ready handshake and a
// two-entry skid buffer (main + skid), so fetch streams at one entry per cycle
// while decode backpressure reaches fetch only through a registered ready.
// Flush synchronously empties both entries and drops any same-cycle accept.
// All state updates on the falling edge of clk.
//
// Ports:
//   clk       : pipeline clock (falling-edge active)
//   reset     : asynchronous active-low reset
//   flush     : synchronous kill of held and incoming entries
//   up        : slave handshake from fetch (valid/pc/inst in, ready out)
//   dn        : master handshake to decode (valid/pc/inst out, ready in);
//               pc=0 and inst=NOP_INST whenever valid is low
//   stall_cnt : cycles with dn.valid & !dn.ready (saturating)
//   flush_cnt : flush cycles while any entry was held (saturating)
//
// Build option: define IF_ID_PERF_CNT_EN to build the two performance
// counters; otherwise stall_cnt and flush_cnt are constant zero.
module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int unsigned       PC_W     = PC_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
  parameter int unsigned       CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  if_id_skid_stage_if.slave    up,
  if_id_skid_stage_if.master   dn,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  localparam entry_t NopEntry = '{pc: PC_W'(0), inst: NOP_INST};

  occ_e   state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  entry_t in_entry;
  logic   main_valid;
  logic   acc;
  logic   drn;

  assign main_valid = state_q[1];
  assign in_entry   = '{pc: up.pc, inst: up.inst};
  assign acc        = up.valid & in_ready_q;
  assign drn        = main_valid & dn.ready;

  // State and data registers
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= OCC_EMPTY;
      main_q     <= NopEntry;
      skid_q     <= NopEntry;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next occupancy and entry contents; flush overrides every handshake
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = OCC_EMPTY;
      main_d  = NopEntry;
      skid_d  = NopEntry;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (acc) begin
            state_d = OCC_ONE;
            main_d  = in_entry;
          end
        end
        OCC_ONE: begin
          if (acc && drn) begin
            main_d = in_entry;
          end else if (acc) begin
            state_d = OCC_FULL;
            skid_d  = in_entry;
          end else if (drn) begin
            state_d = OCC_EMPTY;
            main_d  = NopEntry;
          end
        end
        OCC_FULL: begin
          // ready is low here, so only a drain can happen
          if (drn) begin
            state_d = OCC_ONE;
            main_d  = skid_q;
            skid_d  = NopEntry;
          end
        end
        default: begin
          state_d = OCC_EMPTY;
          main_d  = NopEntry;
          skid_d  = NopEntry;
        end
      endcase
    end

    // Registered ready: deasserts only once the skid entry is occupied
    in_ready_d = (state_d != OCC_FULL);
  end

  assign up.ready = in_ready_q;
  assign dn.valid = main_valid;
  assign dn.pc    = main_q.pc;
  assign dn.inst  = main_q.inst;

  a_occ_legal: assert property (@(negedge clk) disable iff (!reset)
                                occ_legal(state_q));

`ifdef IF_ID_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = main_valid & ~dn.ready;
  assign flush_inc = flush & (state_q != OCC_EMPTY);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: reset, vector table for streaming,
// skid/backpressure and flush, async reset while FULL, and (with
// IF_ID_PERF_CNT_EN) the performance counters including saturation.
module tb_if_id_skid_stage;
  import if_id_skid_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks;
  int errors;

  if_id_skid_stage_if #(.PC_W(32), .INST_W(32)) up_if ();
  if_id_skid_stage_if #(.PC_W(32), .INST_W(32)) dn_if ();

  if_id_skid_stage #(.PC_W(32), .INST_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

`ifdef IF_ID_PERF_CNT_EN
  logic       flush2;
  logic [1:0] stall_cnt2;
  logic [1:0] flush_cnt2;

  if_id_skid_stage_if #(.PC_W(32), .INST_W(32)) up2_if ();
  if_id_skid_stage_if #(.PC_W(32), .INST_W(32)) dn2_if ();

  if_id_skid_stage #(.PC_W(32), .INST_W(32), .CNT_W(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush2),
    .up        (up2_if),
    .dn        (dn2_if),
    .stall_cnt (stall_cnt2),
    .flush_cnt (flush_cnt2)
  );
`endif

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic           iv;
    if_id_payload_t in;
    logic           ordy;
    logic           fl;
    logic           ov;
    if_id_payload_t ex;
    logic           ir;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic iv, input logic [31:0] pc,
                              input logic [31:0] inst, input logic ordy,
                              input logic fl, input logic ov,
                              input logic [31:0] epc, input logic [31:0] einst,
                              input logic ir);
    vec_t v;
    v.iv = iv; v.in.pc = pc; v.in.inst = inst; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.ex.pc = epc; v.ex.inst = einst; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the falling edge pass, settle 1 time unit
  task automatic apply(input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy,
                       input logic fl);
    up_if.valid  = iv;
    up_if.pc     = pc;
    up_if.inst   = inst;
    dn_if.ready  = ordy;
    flush        = fl;
    @(negedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ov,
                         input logic [31:0] pc, input logic [31:0] inst,
                         input logic ir);
    chk({tag, ".out_valid"}, 32'(dn_if.valid), 32'(ov));
    chk({tag, ".out_pc"},    dn_if.pc,         pc);
    chk({tag, ".out_inst"},  dn_if.inst,       inst);
    chk({tag, ".in_ready"},  32'(up_if.ready), 32'(ir));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    flush  = 1'b0;
    up_if.valid = 1'b0; up_if.pc = '0; up_if.inst = '0; dn_if.ready = 1'b0;
`ifdef IF_ID_PERF_CNT_EN
    flush2 = 1'b0;
    up2_if.valid = 1'b0; up2_if.pc = '0; up2_if.inst = '0; dn2_if.ready = 1'b0;
`endif
    #2;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      apply(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      chk_out($sformatf("rst_hold%0d", i), 1'b0, 32'h0, 32'h0, 1'b1);
      chk("rst_hold.stall_cnt", 32'(stall_cnt), 32'h0);
      chk("rst_hold.flush_cnt", 32'(flush_cnt), 32'h0);
    end

    // Release: nothing changes until the first accept
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk_out($sformatf("rst_rel%0d", i), 1'b0, 32'h0, 32'h0, 1'b1);
    end

    //        iv pc     inst   ordy fl  ov pc     inst   ir
    vq.push_back(mk(1, 32'h00, 32'h11, 1, 0, 1, 32'h00, 32'h11, 1)); // stream
    vq.push_back(mk(1, 32'h04, 32'h22, 1, 0, 1, 32'h04, 32'h22, 1));
    vq.push_back(mk(1, 32'h08, 32'h33, 1, 0, 1, 32'h08, 32'h33, 1));
    vq.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0, 32'h00, 32'h00, 1)); // drain
    vq.push_back(mk(1, 32'h10, 32'h44, 1, 0, 1, 32'h10, 32'h44, 1)); // skid
    vq.push_back(mk(1, 32'h14, 32'h55, 0, 0, 1, 32'h10, 32'h44, 0));
    vq.push_back(mk(1, 32'h18, 32'h66, 0, 0, 1, 32'h10, 32'h44, 0));
    vq.push_back(mk(1, 32'h18, 32'h66, 1, 0, 1, 32'h14, 32'h55, 1));
    vq.push_back(mk(1, 32'h18, 32'h66, 1, 0, 1, 32'h18, 32'h66, 1));
    vq.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0, 32'h00, 32'h00, 1));
    vq.push_back(mk(1, 32'h1c, 32'h77, 0, 0, 1, 32'h1c, 32'h77, 1)); // flush FULL
    vq.push_back(mk(1, 32'h24, 32'h88, 0, 0, 1, 32'h1c, 32'h77, 0));
    vq.push_back(mk(1, 32'h20, 32'h99, 0, 1, 0, 32'h00, 32'h00, 1));
    vq.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0, 32'h00, 32'h00, 1));
    vq.push_back(mk(1, 32'h28, 32'haa, 1, 0, 1, 32'h28, 32'haa, 1)); // flush ONE
    vq.push_back(mk(1, 32'h2c, 32'hbb, 1, 1, 0, 32'h00, 32'h00, 1));
    vq.push_back(mk(0, 32'h00, 32'h00, 1, 0, 0, 32'h00, 32'h00, 1));

    foreach (vq[i]) begin
      apply(vq[i].iv, vq[i].in.pc, vq[i].in.inst, vq[i].ordy, vq[i].fl);
      chk_out($sformatf("vec%0d", i), vq[i].ov, vq[i].ex.pc, vq[i].ex.inst,
              vq[i].ir);
    end

    // Async reset in FULL clears outputs with no clock edge
    apply(1'b1, 32'h30, 32'hcc, 1'b0, 1'b0);
    apply(1'b1, 32'h34, 32'hdd, 1'b0, 1'b0);
    chk_out("pre_async", 1'b1, 32'h30, 32'hcc, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b1);
    up_if.valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk_out("post_async", 1'b0, 32'h0, 32'h0, 1'b1);

`ifdef IF_ID_PERF_CNT_EN
    // Five stalled cycles, then two flushes with a held entry
    apply(1'b1, 32'h40, 32'hee, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("perf.stall5", 32'(stall_cnt), 32'd5);
    apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    apply(1'b1, 32'h44, 32'hff, 1'b1, 1'b0);
    apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("perf.stall_cnt", 32'(stall_cnt), 32'd5);
    chk("perf.flush_cnt", 32'(flush_cnt), 32'd2);

    // Two-bit counter saturates after six stalls
    up2_if.valid = 1'b1;
    up2_if.pc    = 32'h50;
    dn2_if.ready = 1'b0;
    @(negedge clk);
    #1;
    up2_if.valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("perf.sat_stall_cnt", 32'(stall_cnt2), 32'd3);
    chk("perf.sat_flush_cnt", 32'(flush_cnt2), 32'd0);
`else
    apply(1'b1, 32'h40, 32'hee, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("nocnt.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("nocnt.flush_cnt", 32'(flush_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
